// File: rtl/isa_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// isa_bus_master_pkg
// Shared definitions for the ISA bus master: FSM state codes, the strobe
// select encoding formed from {mem, write}, and a helper that turns a strobe
// select into the active-low strobe vector {memw_l, memr_l, iow_l, ior_l}.
// No ports (package).
// -----------------------------------------------------------------------------
package isa_bus_master_pkg;

   // FSM state codes
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETUP    = 3'd1;
   localparam logic [2:0] ST_STROBE   = 3'd2;
   localparam logic [2:0] ST_WAIT_RDY = 3'd3;
   localparam logic [2:0] ST_HOLD     = 3'd4;
   localparam logic [2:0] ST_RESP     = 3'd5;

   // Strobe select, encoded as {mem, write}
   typedef enum logic [1:0] {
      SEL_IOR  = 2'b00,
      SEL_IOW  = 2'b01,
      SEL_MEMR = 2'b10,
      SEL_MEMW = 2'b11
   } strb_sel_e;

   localparam logic [3:0] STRB_IDLE = 4'b1111;

   // Active-low strobe vector, bit order {memw_l, memr_l, iow_l, ior_l}
   function automatic logic [3:0] strobe_vec(input strb_sel_e sel);
      logic [3:0] v;
      case (sel)
         SEL_IOR:  v = 4'b1110;
         SEL_IOW:  v = 4'b1101;
         SEL_MEMR: v = 4'b1011;
         SEL_MEMW: v = 4'b0111;
         default:  v = STRB_IDLE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/isa_bus_master_if.sv
// -----------------------------------------------------------------------------
// isa_bus_master_if
// Groups the command/response handshake and the ISA bus pins of the bus
// master. The master modport is the bus master's view; the slave modport is
// the view of whatever issues commands and models the ISA responder.
//   cmd_*   : command request (valid/ready, write, mem, 20-bit addr, wdata)
//   rsp_*   : one-cycle completion pulse with read data and timeout flag
//   bus_*   : ISA address, active-low strobes, AEN, data out/oe, data in, RDY
// -----------------------------------------------------------------------------
interface isa_bus_master_if;
   import isa_bus_master_pkg::*;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_mem;
   logic [19:0] cmd_addr;
   logic [7:0]  cmd_wdata;

   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;

   logic [19:0] bus_a;
   logic        bus_ior_l;
   logic        bus_iow_l;
   logic        bus_memr_l;
   logic        bus_memw_l;
   logic        bus_aen;
   logic [7:0]  bus_d_out;
   logic        bus_d_oe;
   logic [7:0]  bus_d_in;
   logic        bus_rdy;

   modport master (
      input  cmd_valid, cmd_write, cmd_mem, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_timeout,
      output bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
      output bus_aen, bus_d_out, bus_d_oe,
      input  bus_d_in, bus_rdy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_mem, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_timeout,
      input  bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
      input  bus_aen, bus_d_out, bus_d_oe,
      output bus_d_in, bus_rdy
   );

endinterface

// File: rtl/isa_bus_master_rdy_sync.sv
// -----------------------------------------------------------------------------
// isa_rdy_sync
// Two-flop synchronizer for the asynchronous IOCHRDY pin. Resets to 1
// (ready) so a reset never looks like a responder stall.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   rdy_a  : asynchronous ready input
//   rdy_s  : synchronized ready, two clocks of latency
// -----------------------------------------------------------------------------
module isa_rdy_sync (
   input  logic clk,
   input  logic rst,
   input  logic rdy_a,
   output logic rdy_s
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous ready pin
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
      end else begin
         meta_r <= rdy_a;
         sync_r <= meta_r;
      end
   end

   assign rdy_s = sync_r;

endmodule

// File: rtl/isa_bus_master.sv
// -----------------------------------------------------------------------------
// isa_bus_master
// Runs one 8-bit ISA I/O or memory cycle per accepted command:
// IDLE -> SETUP -> STROBE -> WAIT_RDY -> HOLD -> RESP -> IDLE.
// Parameters: SETUP_CYC / STROBE_CYC / HOLD_CYC phase lengths in clk cycles
// (0 behaves as 1), RDY_TIMEOUT maximum WAIT_RDY cycles before abort.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : isa_bus_master_if.master (command, response and ISA pins)
// All outputs are registered.
// -----------------------------------------------------------------------------
module isa_bus_master
   import isa_bus_master_pkg::*;
#(
   parameter int SETUP_CYC   = 2,
   parameter int STROBE_CYC  = 6,
   parameter int HOLD_CYC    = 2,
   parameter int RDY_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   isa_bus_master_if.master  bus
);

   localparam int SETUP_N  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
   localparam int STROBE_N = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
   localparam int HOLD_N   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;
   localparam int TO_N     = (RDY_TIMEOUT < 1) ? 1 : RDY_TIMEOUT;

   localparam logic [15:0] SETUP_LAST  = 16'(SETUP_N - 1);
   localparam logic [15:0] STROBE_LAST = 16'(STROBE_N - 1);
   localparam logic [15:0] HOLD_LAST   = 16'(HOLD_N - 1);
   localparam logic [15:0] TO_LAST     = 16'(TO_N - 1);

   logic [2:0]  state_r;
   logic [15:0] cnt_r;
   logic [15:0] wait_cnt_r;
   logic        write_r;
   strb_sel_e   sel_r;
   logic [3:0]  strb_l_r;

   logic        cmd_ready_r;
   logic        rsp_valid_r;
   logic [7:0]  rsp_rdata_r;
   logic        rsp_timeout_r;
   logic [19:0] bus_a_r;
   logic        bus_aen_r;
   logic [7:0]  bus_d_out_r;
   logic        bus_d_oe_r;

   logic        rdy_sync_s;
   logic        wait_done_s;
   logic        wait_to_s;

   isa_rdy_sync u_rdy_sync (
      .clk   (clk),
      .rst   (rst),
      .rdy_a (bus.bus_rdy),
      .rdy_s (rdy_sync_s)
   );

   // WAIT_RDY exit decision. The synchronized ready lags the pin by two
   // clocks, so WAIT_RDY always spends at least two cycles: a responder that
   // drops RDY in reaction to the strobe is guaranteed to be seen.
   always_comb begin
      wait_done_s = 1'b0;
      wait_to_s   = 1'b0;
      if (rdy_sync_s && (wait_cnt_r != 16'd0)) begin
         wait_done_s = 1'b1;
         wait_to_s   = 1'b0;
      end else if (wait_cnt_r == TO_LAST) begin
         wait_done_s = 1'b1;
         wait_to_s   = 1'b1;
      end else begin
         wait_done_s = 1'b0;
         wait_to_s   = 1'b0;
      end
   end

   // Bus cycle FSM and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 16'd0;
         wait_cnt_r    <= 16'd0;
         write_r       <= 1'b0;
         sel_r         <= SEL_IOR;
         strb_l_r      <= STRB_IDLE;
         cmd_ready_r   <= 1'b1;
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= 8'h00;
         rsp_timeout_r <= 1'b0;
         bus_a_r       <= 20'h00000;
         bus_aen_r     <= 1'b1;
         bus_d_out_r   <= 8'h00;
         bus_d_oe_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  state_r     <= ST_SETUP;
                  cnt_r       <= 16'd0;
                  cmd_ready_r <= 1'b0;
                  write_r     <= bus.cmd_write;
                  sel_r       <= strb_sel_e'({bus.cmd_mem, bus.cmd_write});
                  bus_a_r     <= bus.cmd_addr;
                  bus_aen_r   <= 1'b0;
                  bus_d_oe_r  <= bus.cmd_write;
                  bus_d_out_r <= bus.cmd_write ? bus.cmd_wdata : 8'h00;
               end
            end
            ST_SETUP: begin
               if (cnt_r == SETUP_LAST) begin
                  state_r  <= ST_STROBE;
                  cnt_r    <= 16'd0;
                  strb_l_r <= strobe_vec(sel_r);
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_STROBE: begin
               if (cnt_r == STROBE_LAST) begin
                  state_r    <= ST_WAIT_RDY;
                  cnt_r      <= 16'd0;
                  wait_cnt_r <= 16'd0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_WAIT_RDY: begin
               if (wait_done_s) begin
                  // Last strobe-low cycle: capture read data, release next edge
                  state_r       <= ST_HOLD;
                  cnt_r         <= 16'd0;
                  strb_l_r      <= STRB_IDLE;
                  rsp_rdata_r   <= write_r ? 8'h00 : bus.bus_d_in;
                  rsp_timeout_r <= wait_to_s;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
            end
            ST_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  state_r     <= ST_RESP;
                  cnt_r       <= 16'd0;
                  rsp_valid_r <= 1'b1;
                  bus_aen_r   <= 1'b1;
                  bus_d_oe_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_RESP: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
               cnt_r       <= 16'd0;
               wait_cnt_r  <= 16'd0;
            end
            default: begin
               state_r     <= ST_IDLE;
               strb_l_r    <= STRB_IDLE;
               cmd_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
               bus_aen_r   <= 1'b1;
               bus_d_oe_r  <= 1'b0;
               cnt_r       <= 16'd0;
               wait_cnt_r  <= 16'd0;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = cmd_ready_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_rdata   = rsp_rdata_r;
   assign bus.rsp_timeout = rsp_timeout_r;
   assign bus.bus_a       = bus_a_r;
   assign bus.bus_ior_l   = strb_l_r[0];
   assign bus.bus_iow_l   = strb_l_r[1];
   assign bus.bus_memr_l  = strb_l_r[2];
   assign bus.bus_memw_l  = strb_l_r[3];
   assign bus.bus_aen     = bus_aen_r;
   assign bus.bus_d_out   = bus_d_out_r;
   assign bus.bus_d_oe    = bus_d_oe_r;

endmodule

// File: tb/tb_isa_bus_master.sv
// -----------------------------------------------------------------------------
// tb_isa_bus_master
// Directed self-checking bench for isa_bus_master (SETUP 2, STROBE 6, HOLD 2,
// RDY_TIMEOUT 20). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_isa_bus_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   isa_bus_master_if bif ();

   isa_bus_master #(
      .SETUP_CYC   (2),
      .STROBE_CYC  (6),
      .HOLD_CYC    (2),
      .RDY_TIMEOUT (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   // results of the last run_cmd
   int          low_ior, low_iow, low_memr, low_memw, overlap, lat;
   logic        got_rsp, r_tmo, aen_during, oe_during, aen_resp, oe_resp, rdy_after;
   logic [7:0]  r_rdata, dout_seen;
   logic [19:0] a_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic count_strobes();
      int n;
      n = 0;
      if (bif.bus_ior_l  === 1'b0) begin low_ior++;  n++; end
      if (bif.bus_iow_l  === 1'b0) begin low_iow++;  n++; end
      if (bif.bus_memr_l === 1'b0) begin low_memr++; n++; end
      if (bif.bus_memw_l === 1'b0) begin low_memw++; n++; end
      if (n > 1) overlap++;
   endtask

   // mode 0: rdy high; mode 1: rdy low for 10 cycles from strobe fall; mode 2: rdy held low
   task automatic run_cmd(input logic wr, input logic mem, input logic [19:0] addr,
                          input logic [7:0] wd, input int mode);
      int   rem;
      logic seen_low;
      low_ior = 0; low_iow = 0; low_memr = 0; low_memw = 0; overlap = 0; lat = 0;
      got_rsp = 1'b0; r_tmo = 1'b0; r_rdata = 8'h00; rdy_after = 1'b0;
      aen_during = 1'b1; oe_during = 1'b0; aen_resp = 1'b0; oe_resp = 1'b1;
      dout_seen = 8'h00; a_seen = 20'h00000;
      rem = 0; seen_low = 1'b0;
      @(negedge clk);
      bif.cmd_valid = 1'b1; bif.cmd_write = wr; bif.cmd_mem = mem;
      bif.cmd_addr = addr; bif.cmd_wdata = wd;
      @(negedge clk);
      bif.cmd_valid = 1'b0;
      if (mode == 2) bif.bus_rdy = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 1) begin aen_during = bif.bus_aen; oe_during = bif.bus_d_oe; end
         if (rem > 0) begin
            rem--;
            if (rem == 0) bif.bus_rdy = 1'b1;
         end
         count_strobes();
         if ((bif.bus_ior_l & bif.bus_iow_l & bif.bus_memr_l & bif.bus_memw_l) === 1'b0) begin
            a_seen = bif.bus_a; dout_seen = bif.bus_d_out;
            if (!seen_low) begin
               seen_low = 1'b1;
               if (mode == 1) begin bif.bus_rdy = 1'b0; rem = 10; end
            end
         end
         if (bif.rsp_valid === 1'b1) begin
            got_rsp = 1'b1; lat = k; r_rdata = bif.rsp_rdata; r_tmo = bif.rsp_timeout;
            aen_resp = bif.bus_aen; oe_resp = bif.bus_d_oe;
            break;
         end
      end
      bif.bus_rdy = 1'b1;
      @(negedge clk);
      rdy_after = bif.cmd_ready;
   endtask

   initial begin
      int rsp_cnt, idle_between, post_rsp;
      logic [7:0] rd1, rd2;
      logic hit;
      bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_mem = 1'b0;
      bif.cmd_addr = 20'h00000; bif.cmd_wdata = 8'h00;
      bif.bus_d_in = 8'h41; bif.bus_rdy = 1'b1;

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_strobes", {bif.bus_memw_l, bif.bus_memr_l, bif.bus_iow_l, bif.bus_ior_l}, 4'hF);
      chk("rst_aen", bif.bus_aen, 1'b1);
      chk("rst_d_oe", bif.bus_d_oe, 1'b0);
      chk("rst_bus_a", bif.bus_a, 20'h00000);
      chk("rst_d_out", bif.bus_d_out, 8'h00);
      chk("rst_cmd_ready", bif.cmd_ready, 1'b1);
      chk("rst_rsp", {bif.rsp_valid, bif.rsp_timeout, bif.rsp_rdata}, 10'h000);

      // IO write 0x3D8 <- 0x29, rdy high: iow low 6+2, RESP 13 cycles after accept
      run_cmd(1'b1, 1'b0, 20'h003D8, 8'h29, 0);
      chk("iow_rsp_seen", got_rsp, 1'b1);
      chk("iow_low_cycles", low_iow, 8);
      chk("iow_other_strobes", low_ior + low_memr + low_memw, 0);
      chk("iow_bus_a", a_seen, 20'h003D8);
      chk("iow_d_out", dout_seen, 8'h29);
      chk("iow_aen_oe_during", {aen_during, oe_during}, 2'b01);
      chk("iow_latency", lat, 13);
      chk("iow_timeout", r_tmo, 1'b0);
      chk("iow_rdata", r_rdata, 8'h00);
      chk("iow_aen_oe_resp", {aen_resp, oe_resp}, 2'b10);
      chk("iow_ready_after", rdy_after, 1'b1);

      // Mem read 0xB8000, responder data 0x41
      run_cmd(1'b0, 1'b1, 20'hB8000, 8'hFF, 0);
      chk("memr_low_cycles", low_memr, 8);
      chk("memr_other_strobes", low_ior + low_iow + low_memw, 0);
      chk("memr_bus_a", a_seen, 20'hB8000);
      chk("memr_oe_during", oe_during, 1'b0);
      chk("memr_rdata", r_rdata, 8'h41);
      chk("memr_timeout", r_tmo, 1'b0);

      // Mem write 0xB8001, rdy low for 10 cycles from strobe fall:
      // strobe low = 10 rdy-low + 2 synchronizer + 1 release decision = 13
      run_cmd(1'b1, 1'b1, 20'hB8001, 8'h7E, 1);
      chk("memw_wait_rsp_seen", got_rsp, 1'b1);
      chk("memw_wait_low_cycles", low_memw, 13);
      chk("memw_wait_timeout", r_tmo, 1'b0);
      chk("memw_wait_d_out", dout_seen, 8'h7E);

      // Mem write with rdy held low: 6 STROBE + 20 WAIT_RDY cycles, then abort
      run_cmd(1'b1, 1'b1, 20'hB8002, 8'h55, 2);
      chk("to_rsp_seen", got_rsp, 1'b1);
      chk("to_low_cycles", low_memw, 26);
      chk("to_timeout", r_tmo, 1'b1);
      chk("to_rdata", r_rdata, 8'h00);

      // Reset during STROBE of IO read 0x3DA
      @(negedge clk);
      bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0; bif.cmd_mem = 1'b0; bif.cmd_addr = 20'h003DA;
      @(negedge clk);
      bif.cmd_valid = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bif.bus_ior_l === 1'b0) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      chk("rstmid_strobe_reached", hit, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_strobes", {bif.bus_memw_l, bif.bus_memr_l, bif.bus_iow_l, bif.bus_ior_l}, 4'hF);
      chk("rstmid_aen", bif.bus_aen, 1'b1);
      rst = 1'b0;
      rsp_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bif.rsp_valid === 1'b1) rsp_cnt++;
      end
      chk("rstmid_no_rsp", rsp_cnt, 0);
      bif.bus_d_in = 8'hA5;
      run_cmd(1'b0, 1'b0, 20'h003DA, 8'h00, 0);
      chk("rstmid_next_ior_cycles", low_ior, 8);
      chk("rstmid_next_rdata", r_rdata, 8'hA5);
      chk("rstmid_next_latency", lat, 13);

      // Back-to-back: cmd_valid held; IO write 0x300 then mem read 0xC0000
      low_ior = 0; low_iow = 0; low_memr = 0; low_memw = 0; overlap = 0;
      rsp_cnt = 0; idle_between = 0; post_rsp = 0; rd1 = 8'hFF; rd2 = 8'hFF;
      @(negedge clk);
      bif.cmd_valid = 1'b1; bif.cmd_write = 1'b1; bif.cmd_mem = 1'b0;
      bif.cmd_addr = 20'h00300; bif.cmd_wdata = 8'h11;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         count_strobes();
         if (bif.rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (rsp_cnt == 1) begin
               rd1 = bif.rsp_rdata;
               bif.cmd_write = 1'b0; bif.cmd_mem = 1'b1; bif.cmd_addr = 20'hC0000;
            end else begin
               rd2 = bif.rsp_rdata;
            end
         end else if (rsp_cnt == 1 && bif.cmd_ready === 1'b1) begin
            idle_between++;
         end
         if (rsp_cnt >= 1 && bif.cmd_ready === 1'b0 && bif.rsp_valid === 1'b0)
            bif.cmd_valid = 1'b0;
      end
      chk("b2b_rsp_count", rsp_cnt, 2);
      chk("b2b_idle_between", idle_between, 1);
      chk("b2b_iow_cycles", low_iow, 8);
      chk("b2b_memr_cycles", low_memr, 8);
      chk("b2b_overlap", overlap, 0);
      chk("b2b_rdata", {rd1, rd2}, 16'h00A5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/isa_bus_master.md
ISA_BUS_MASTER -- requirements
Module: isa_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 2, clk cycles of address valid before command strobe asserts.
REQ-002 Parameter STROBE_CYC, default 6, minimum clk cycles a command strobe stays low.
REQ-003 Parameter HOLD_CYC, default 2, clk cycles address/write data held after strobe release.
REQ-004 Parameter RDY_TIMEOUT, default 255, maximum clk cycles of bus_rdy low before cycle abort.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_mem  in  1  1=memory cycle (MEMR/MEMW), 0=I/O cycle (IOR/IOW).
REQ-011 cmd_addr  in  20  ISA address.
REQ-012 cmd_wdata  in  8  write data.
REQ-013 rsp_valid  out  1  one-cycle pulse, cycle complete.
REQ-014 rsp_rdata  out  8  read data, valid with rsp_valid (0x00 for writes).
REQ-015 rsp_timeout  out  1  valid with rsp_valid; 1 = cycle aborted by RDY_TIMEOUT.
REQ-016 bus_a  out  20  ISA address.
REQ-017 bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  active-low command strobes.
REQ-018 bus_aen  out  1  held 0 (CPU cycle) during every cycle, 1 when idle.
REQ-019 bus_d_out  out  8  write data; bus_d_oe  out  1  drive enable for bus_d_out.
REQ-020 bus_d_in  in  8  read data from responder; bus_rdy  in  1  IOCHRDY, asynchronous.

Function
REQ-021 States: IDLE, SETUP, STROBE, WAIT_RDY, HOLD, RESP; cmd_ready=1 only in IDLE.
REQ-022 IDLE: on cmd_valid, latch cmd fields, drive bus_a, bus_aen=0, bus_d_oe=cmd_write, go SETUP next cycle.
REQ-023 SETUP: count SETUP_CYC cycles, then assert exactly one strobe selected by {cmd_mem,cmd_write}.
REQ-024 STROBE: count STROBE_CYC cycles with strobe low; then WAIT_RDY.
REQ-025 bus_rdy passes a 2-flop synchronizer; WAIT_RDY exits to HOLD on first cycle synced rdy=1.
REQ-026 WAIT_RDY counter 8+ bits; on count reaching RDY_TIMEOUT go HOLD with timeout flag set.
REQ-027 Read data sampled from bus_d_in on the last cycle strobe is low; strobe deasserts the following cycle.
REQ-028 HOLD: strobe high, bus_a/bus_d_out/bus_d_oe unchanged for HOLD_CYC cycles, then RESP.
REQ-029 RESP: rsp_valid=1 one cycle, bus_aen=1, bus_d_oe=0, return IDLE; cmd_ready=1 the cycle after RESP.
REQ-030 Strobes never two low at once; strobe never low outside STROBE/WAIT_RDY.
REQ-031 Minimum cycle length with bus_rdy=1: 1+SETUP_CYC+STROBE_CYC+2 (synchronizer)+HOLD_CYC+1 clks.
REQ-032 cmd_* inputs ignored outside IDLE; no queueing; back-to-back commands separated by one IDLE cycle.
REQ-033 SETUP_CYC, STROBE_CYC, HOLD_CYC of 0 treated as 1.

Reset
REQ-034 rst forces IDLE next edge, regardless of state, including strobe low mid-cycle.
REQ-035 Reset values: all strobes 1, bus_aen 1, bus_d_oe 0, bus_a 0, bus_d_out 0, cmd_ready 1 after first post-reset cycle, rsp_valid 0, rsp_rdata 0, rsp_timeout 0, counters 0, synchronizer 1.
REQ-036 Command aborted by reset produces no rsp_valid.

Structure
REQ-037 Shared package holds state enumeration and strobe select encoding {mem,write}; timing defaults stay parameters.
REQ-038 One sub-module natural: isa_rdy_sync (2-flop synchronizer, reset value 1).

Verification
REQ-039 IO write 0x3D8 data 0x29, rdy=1 -> bus_iow_l low 6+2 cycles, bus_a=0x003D8, bus_d_out=0x29, rsp_valid, rsp_timeout=0.
REQ-040 Mem read 0xB8000, responder drives 0x41, rdy=1 -> bus_memr_l only strobe low, rsp_rdata=0x41.
REQ-041 Mem write 0xB8001 with bus_rdy low 10 cycles after strobe -> strobe extended by 10 cycles + sync, completes without timeout.
REQ-042 bus_rdy held low, RDY_TIMEOUT=20 -> strobe released after 20 WAIT_RDY cycles, rsp_timeout=1, rsp_rdata=0x00 for write.
REQ-043 rst pulsed during STROBE of IO read 0x3DA -> all strobes 1 and bus_aen 1 next cycle, no rsp_valid, next command runs normally.
REQ-044 Two back-to-back commands with cmd_valid held -> exactly two cycles, one IDLE cycle between, strobes never overlapping.
